result_streamer: RTL

- Sits directly downstream of the result aggregator.
- Snapshots the reconstructed 2*PIM_MATRIX_SIZE square result matrix when the aggregator pulses result_ready.
- Streams the active matrix_size x matrix_size region out one element per beat, row-major, over a valid/ready interface toward host writeback.
- Decouples the aggregator's one-cycle result pulse from a back-pressured consumer.

---
 rtl/result_streamer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/result_streamer.sv
// ----------------------------------------------------------------------------
// result_streamer
//
// Captures the full reconstructed result matrix from the aggregator on its
// one-cycle result_ready pulse. It then streams the active n x n region, row
// by row, one element per beat over a valid/ready interface. A held snapshot
// means the aggregator can move on while a back-pressured consumer drains
// the previous result.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   final_result  FULL x FULL matrix of ELEM_WIDTH elements (FULL = 2*PIM_MATRIX_SIZE)
//   result_ready  one-cycle pulse, final_result/matrix_size valid
//   matrix_size   active edge length n (0 = ignore, >FULL = FULL)
//   out_data      current element
//   out_row       row index of out_data
//   out_col       column index of out_data
//   out_valid     beat valid
//   out_last      beat is element (n-1, n-1)
//   out_ready     consumer accepts the beat when out_valid && out_ready
//   busy          high while streaming
//   done          one-cycle pulse after the last beat is accepted
//   drop_count    saturating count of pulses ignored while busy
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for result_ready with a non-zero matrix_size
// ST_STREAM | presenting snapshot[row][col]; advancing on each accept
// ----------------------------------------------------------------------------
module result_streamer #(
    parameter int ELEM_WIDTH      = 32,
    parameter int PIM_MATRIX_SIZE = 8,
    localparam int FULL           = 2 * PIM_MATRIX_SIZE,
    localparam int IDX_W          = $clog2(FULL)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ELEM_WIDTH-1:0] final_result [0:FULL-1][0:FULL-1],
    input  logic                  result_ready,
    input  logic [15:0]           matrix_size,
    output logic [ELEM_WIDTH-1:0] out_data,
    output logic [IDX_W-1:0]      out_row,
    output logic [IDX_W-1:0]      out_col,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            drop_count
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    localparam logic [IDX_W:0] FULL_N  = FULL[IDX_W:0];
    localparam logic [15:0]    FULL_16 = FULL[15:0];

    logic [0:0]            state;
    logic [IDX_W:0]        n_m1;
    logic [ELEM_WIDTH-1:0] snapshot [0:FULL-1][0:FULL-1];

    logic [IDX_W:0]        n_clamp;
    logic                  start;
    logic                  accept;
    logic                  col_wrap;
    logic [IDX_W-1:0]      next_row;
    logic [IDX_W-1:0]      next_col;
    logic                  next_last;

    always_comb begin
        n_clamp = (matrix_size > FULL_16) ? FULL_N : matrix_size[IDX_W:0];
    end

    assign start  = (state == ST_IDLE) && result_ready && (n_clamp != '0);
    assign accept = (state == ST_STREAM) && out_ready;

    // Row-major advance; counters compare against the latched n-1 so they
    // never run past the active region.
    always_comb begin
        col_wrap  = ({1'b0, out_col} == n_m1);
        next_col  = col_wrap ? '0 : out_col + 1'b1;
        next_row  = col_wrap ? out_row + 1'b1 : out_row;
        next_last = ({1'b0, next_row} == n_m1) && ({1'b0, next_col} == n_m1);
    end

    // Snapshot storage carries no reset; it is only read after a capture.
    always_ff @(posedge clk) begin
        if (start) begin
            snapshot <= final_result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            n_m1       <= '0;
            out_data   <= '0;
            out_row    <= '0;
            out_col    <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            drop_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_STREAM;
                        n_m1      <= n_clamp - 1'b1;
                        out_row   <= '0;
                        out_col   <= '0;
                        // Snapshot loads on this same edge, so the first
                        // element comes straight from the input bus.
                        out_data  <= final_result[0][0];
                        out_valid <= 1'b1;
                        out_last  <= (n_clamp == {{IDX_W{1'b0}}, 1'b1});
                        busy      <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (result_ready && (drop_count != 8'hFF)) begin
                        drop_count <= drop_count + 8'd1;
                    end
                    if (accept) begin
                        if (out_last) begin
                            state     <= ST_IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_data  <= '0;
                            out_row   <= '0;
                            out_col   <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            out_row  <= next_row;
                            out_col  <= next_col;
                            out_data <= snapshot[next_row][next_col];
                            out_last <= next_last;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
